// File: rtl/rx_serial_7e1_pkg.sv
// Shared definitions for the 7E1 serial receiver: state codes, widths, baud divisor helper.
// Latency: n/a (declarations only).
// Backpressure: n/a; the receiver has no flow control, each frame is reported once.
package rx_serial_7e1_pkg;

    localparam int CNT_W     = 13;  // wide enough for 50 MHz / 9600 baud
    localparam int DATA_BITS = 7;

    // db_estado exposes these codes directly, so the values are fixed.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_DADOS    = 4'd2,
        ST_PARIDADE = 4'd3,
        ST_STOP     = 4'd4,
        ST_FINAL    = 4'd5,
        ST_ESPERA   = 4'd6
    } estado_t;

    function automatic int calc_divisor(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/rx_serial_7e1_contador_baud.sv
// Bit-timing counter: counts 0..M-1 and wraps, flags the last count (fim) and the half point (meio).
// Latency: flags are combinational from the registered count.
// Backpressure: none; clr restarts the count from 0 on the next cycle.
module rx_serial_7e1_contador_baud #(
    parameter int M    = 5208,
    parameter int HALF = 2604
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic fim,
    output logic meio
);
    import rx_serial_7e1_pkg::*;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count: clear wins, otherwise wrap at M-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (cnt_q == CNT_W'(M - 1))
            cnt_d = '0;
        else
            cnt_d = cnt_q + 1'b1;
    end

    // count register
    always_ff @(posedge clock) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign fim  = (cnt_q == CNT_W'(M - 1));
    assign meio = (cnt_q == CNT_W'(HALF - 1));

endmodule

// File: rtl/rx_serial_7e1.sv
// Asynchronous 7E1 serial receiver: start, 7 data bits LSB-first, even parity, one stop bit.
// Latency: pronto rises HALF + 9*DIVISOR + 1 clocks after IDLE sees the synchronized start edge.
// Backpressure: none; each frame yields a one-cycle pronto with data and parity/framing flags.
module rx_serial_7e1 #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dados_serial,
    output logic [6:0] dados_ascii,
    output logic       paridade_ok,
    output logic       erro_stop,
    output logic       pronto,
    output logic       db_tick,
    output logic [3:0] db_estado
);
    import rx_serial_7e1_pkg::*;

    localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD);
    localparam int HALF    = DIVISOR / 2;

    logic [1:0]           sync_q, sync_d;
    estado_t              estado_q, estado_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] dados_ascii_q, dados_ascii_d;
    logic                 paridade_ok_q, paridade_ok_d;
    logic                 erro_stop_q, erro_stop_d;
    logic                 pronto_q, pronto_d;
    logic                 clr, tick, fim, meio, line;

    rx_serial_7e1_contador_baud #(
        .M    (DIVISOR),
        .HALF (HALF)
    ) u_contador (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .fim   (fim),
        .meio  (meio)
    );

    assign line = sync_q[1];

    // FSM next state, shift register and output staging; outputs are loaded on entry to FINAL
    // so that pronto and the data it qualifies appear in the same cycle.
    always_comb begin
        sync_d        = {sync_q[0], dados_serial};
        estado_d      = estado_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        par_d         = par_q;
        dados_ascii_d = dados_ascii_q;
        paridade_ok_d = paridade_ok_q;
        erro_stop_d   = erro_stop_q;
        pronto_d      = 1'b0;
        clr           = 1'b0;
        tick          = 1'b0;
        case (estado_q)
            ST_IDLE: begin
                clr = 1'b1;
                if (!line)
                    estado_d = ST_START;
            end
            ST_START: begin
                if (meio) begin
                    clr = 1'b1;
                    if (line) begin
                        estado_d = ST_IDLE;  // too short to be a start bit
                    end else begin
                        estado_d = ST_DADOS;
                        idx_d    = 3'd0;
                    end
                end
            end
            ST_DADOS: begin
                if (fim) begin
                    tick    = 1'b1;
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'(DATA_BITS - 1))
                        estado_d = ST_PARIDADE;
                end
            end
            ST_PARIDADE: begin
                if (fim) begin
                    tick     = 1'b1;
                    par_d    = ~^{shift_q, line};
                    estado_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fim) begin
                    tick          = 1'b1;
                    dados_ascii_d = shift_q;
                    paridade_ok_d = par_q;
                    erro_stop_d   = ~line;
                    pronto_d      = 1'b1;
                    estado_d      = ST_FINAL;
                end
            end
            ST_FINAL: begin
                clr = 1'b1;
                // a low stop bit may be a break: wait for the line to idle before re-arming
                estado_d = erro_stop_q ? ST_ESPERA : ST_IDLE;
            end
            ST_ESPERA: begin
                clr = 1'b1;
                if (line)
                    estado_d = ST_IDLE;
            end
            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    // state, synchronizer and output registers; synchronizer resets to the idle-high level
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q        <= 2'b11;
            estado_q      <= ST_IDLE;
            idx_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            dados_ascii_q <= '0;
            paridade_ok_q <= 1'b0;
            erro_stop_q   <= 1'b0;
            pronto_q      <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            estado_q      <= estado_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            dados_ascii_q <= dados_ascii_d;
            paridade_ok_q <= paridade_ok_d;
            erro_stop_q   <= erro_stop_d;
            pronto_q      <= pronto_d;
        end
    end

    assign dados_ascii = dados_ascii_q;
    assign paridade_ok = paridade_ok_q;
    assign erro_stop   = erro_stop_q;
    assign pronto      = pronto_q;
    assign db_tick     = tick;
    assign db_estado   = estado_q;

endmodule
